// File: rtl/mips_mem_port_pkg.sv
// Shared types for the MIPS memory port: memory operations, port FSM states,
// channel ids and small offset-classification helpers.
package mips_mem_port_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mem_port_state_t;

    localparam logic CH_FETCH = 1'b0;
    localparam logic CH_DATA  = 1'b1;

    function automatic logic is_store(mem_op_t op);
        case (op)
            SB, SH, SW: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // Offset actually used on the bus: halfwords drop bit 0, words drop both bits.
    function automatic logic [1:0] align_offset(mem_op_t op, logic [1:0] offset);
        case (op)
            LH, LHU, SH: return {offset[1], 1'b0};
            LW, SW:      return 2'b00;
            default:     return offset;
        endcase
    endfunction

    function automatic logic is_misaligned(mem_op_t op, logic [1:0] offset);
        return align_offset(op, offset) != offset;
    endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Byte-lane steering between big-endian CPU values and the little-lane Avalon bus:
// byteenable and writedata for stores, merged/extended load result for loads.
module mem_lane_format
    import mips_mem_port_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [31:0] rd_swap_s;
    logic [31:0] rd_shift_s;
    logic [15:0] half_s;
    logic [4:0]  shl_s;
    logic [4:0]  shr_s;

    // Lane selection per operation; lane k carries memory byte at offset k.
    always_comb begin
        rd_swap_s  = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
        shl_s      = {offset, 3'b000};
        shr_s      = {~offset, 3'b000};
        rd_shift_s = readdata >> shl_s;
        half_s     = {rd_shift_s[7:0], rd_shift_s[15:8]};
        byteenable = 4'b0000;
        writedata  = 32'h0000_0000;
        load_data  = 32'h0000_0000;
        case (op)
            LB: begin
                byteenable = 4'b0001 << offset;
                load_data  = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
            end
            LBU: begin
                byteenable = 4'b0001 << offset;
                load_data  = {24'h00_0000, rd_shift_s[7:0]};
            end
            LH: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                load_data  = {{16{half_s[15]}}, half_s};
            end
            LHU: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                load_data  = {16'h0000, half_s};
            end
            LW: begin
                byteenable = 4'b1111;
                load_data  = rd_swap_s;
            end
            LWL: begin
                byteenable = 4'b1111 << offset;
                load_data  = (rd_swap_s << shl_s) | (rt_old & ~(32'hFFFF_FFFF << shl_s));
            end
            LWR: begin
                byteenable = 4'b1111 >> (~offset);
                load_data  = (rd_swap_s >> shr_s) | (rt_old & ~(32'hFFFF_FFFF >> shr_s));
            end
            SB: begin
                byteenable = 4'b0001 << offset;
                writedata  = {24'h00_0000, wdata[7:0]} << shl_s;
            end
            SH: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                writedata  = {16'h0000, wdata[7:0], wdata[15:8]} << shl_s;
            end
            SW: begin
                byteenable = 4'b1111;
                writedata  = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
            end
            default: begin
                byteenable = 4'b0000;
                writedata  = 32'h0000_0000;
                load_data  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mips_mem_port.sv
// Dual-channel (fetch/data) Avalon-MM memory port with big-endian byte-lane handling.
// Define MIPS_MEM_ALIGN_TRAP_EN to answer misaligned accesses with err instead of aligning them.
module mips_mem_port
    import mips_mem_port_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic [3:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [31:0]       d_rt_old,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

`ifdef MIPS_MEM_ALIGN_TRAP_EN
    localparam logic ALIGN_TRAP = 1'b1;
`else
    localparam logic ALIGN_TRAP = 1'b0;
`endif
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    mem_port_state_t   state_r;
    logic              last_grant_r, grant_r, busy_r;
    logic [31:0]       timer_r;
    logic [ADDR_W-1:0] address_r;
    logic              read_r, write_r;
    logic [3:0]        byteenable_r;
    logic [31:0]       writedata_r;
    logic              if_ready_r, if_err_r, d_ready_r, d_err_r;
    logic [31:0]       if_rdata_r, d_rdata_r;

    logic              grant_s, sel_s, misalign_s, timeout_hit_s;
    mem_op_t           op_s;
    logic [1:0]        raw_off_s, eff_off_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s, load_s;

    // Round-robin pick among pending requests; the channel served last loses a tie.
    always_comb begin
        if (if_req && d_req) begin
            grant_s = ~last_grant_r;
        end else if (d_req) begin
            grant_s = CH_DATA;
        end else begin
            grant_s = CH_FETCH;
        end
    end

    // Steer the channel being granted (IDLE) or served (BUS) into the lane formatter.
    always_comb begin
        sel_s = (state_r == IDLE) ? grant_s : grant_r;
        if (sel_s == CH_DATA) begin
            op_s        = mem_op_t'(d_op);
            raw_off_s   = d_addr[1:0];
            word_addr_s = {d_addr[ADDR_W-1:2], 2'b00};
        end else begin
            op_s        = LW;
            raw_off_s   = if_addr[1:0];
            word_addr_s = {if_addr[ADDR_W-1:2], 2'b00};
        end
        eff_off_s     = align_offset(op_s, raw_off_s);
        misalign_s    = ALIGN_TRAP & is_misaligned(op_s, raw_off_s);
        timeout_hit_s = (TIMEOUT_LIM != 32'd0) && ((timer_r + 32'd1) == TIMEOUT_LIM);
    end

    mem_lane_format u_lane (
        .op         (op_s),
        .offset     (eff_off_s),
        .wdata      (d_wdata),
        .rt_old     (d_rt_old),
        .readdata   (readdata),
        .byteenable (be_s),
        .writedata  (wdata_s),
        .load_data  (load_s)
    );

    // Port FSM: arbitration, bus strobes, timeout and one-cycle response pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= CH_FETCH;
            grant_r      <= CH_FETCH;
            busy_r       <= 1'b0;
            timer_r      <= 32'd0;
            address_r    <= {ADDR_W{1'b0}};
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            byteenable_r <= 4'b0000;
            writedata_r  <= 32'd0;
            if_ready_r   <= 1'b0;
            if_err_r     <= 1'b0;
            if_rdata_r   <= 32'd0;
            d_ready_r    <= 1'b0;
            d_err_r      <= 1'b0;
            d_rdata_r    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (if_req || d_req) begin
                        grant_r      <= grant_s;
                        last_grant_r <= grant_s;
                        busy_r       <= 1'b1;
                        if (misalign_s) begin
                            state_r <= RESP;
                            if (grant_s == CH_DATA) begin
                                d_ready_r <= 1'b1;
                                d_err_r   <= 1'b1;
                                d_rdata_r <= 32'd0;
                            end else begin
                                if_ready_r <= 1'b1;
                                if_err_r   <= 1'b1;
                                if_rdata_r <= 32'd0;
                            end
                        end else begin
                            state_r      <= BUS;
                            address_r    <= word_addr_s;
                            read_r       <= ~is_store(op_s);
                            write_r      <= is_store(op_s);
                            byteenable_r <= be_s;
                            writedata_r  <= wdata_s;
                            timer_r      <= 32'd0;
                        end
                    end
                end
                BUS: begin
                    // waitrequest still high here means the timeout fired.
                    if (!waitrequest || timeout_hit_s) begin
                        state_r <= RESP;
                        read_r  <= 1'b0;
                        write_r <= 1'b0;
                        if (grant_r == CH_DATA) begin
                            d_ready_r <= 1'b1;
                            d_err_r   <= waitrequest;
                            d_rdata_r <= waitrequest ? 32'd0 : load_s;
                        end else begin
                            if_ready_r <= 1'b1;
                            if_err_r   <= waitrequest;
                            if_rdata_r <= waitrequest ? 32'd0 : load_s;
                        end
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    if_ready_r <= 1'b0;
                    if_err_r   <= 1'b0;
                    d_ready_r  <= 1'b0;
                    d_err_r    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    read_r     <= 1'b0;
                    write_r    <= 1'b0;
                    if_ready_r <= 1'b0;
                    d_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign address    = address_r;
    assign read       = read_r;
    assign write      = write_r;
    assign byteenable = byteenable_r;
    assign writedata  = writedata_r;
    assign if_ready   = if_ready_r;
    assign if_err     = if_err_r;
    assign if_rdata   = if_rdata_r;
    assign d_ready    = d_ready_r;
    assign d_err      = d_err_r;
    assign d_rdata    = d_rdata_r;

endmodule
